// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU control codes and RV32I opcodes.
package alu_pkg;

    // ALU control codes carried on ctrlSig
    localparam logic [3:0] ALU_NOT = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_RS  = 4'b0110;
    localparam logic [3:0] ALU_LS  = 4'b0111;
    localparam logic [3:0] ALU_CMP = 4'b1000;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU control and op attributes.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] ctrl_sig_o,
    output logic       use_imm_o,
    output logic       is_branch_o,
    output logic       wr_en_o,
    output logic       illegal_o
);

    logic [3:0] arith_ctrl;
    logic       arith_ill;

    // Shared funct3 map for OP and OP-IMM; funct7b5 only selects SUB on register ops
    always_comb begin
        arith_ctrl = ALU_NOT;
        arith_ill  = 1'b0;
        case (funct3_i)
            3'b000: arith_ctrl = (opcode_i == OPC_OP && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b100: arith_ctrl = ALU_XOR;
            3'b110: arith_ctrl = ALU_OR;
            3'b111: arith_ctrl = ALU_AND;
            3'b001: arith_ctrl = ALU_LS;
            3'b101: begin
                arith_ctrl = ALU_RS;
                arith_ill  = funct7b5_i;   // arithmetic right shift is not supported
            end
            default: arith_ctrl = ALU_CMP; // 010 / 011
        endcase
    end

    // Opcode-level decode; illegal ops fall back to a harmless NOT with no side effects
    always_comb begin
        ctrl_sig_o  = ALU_NOT;
        use_imm_o   = 1'b0;
        is_branch_o = 1'b0;
        wr_en_o     = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OPC_OP, OPC_OPIMM: begin
                use_imm_o = (opcode_i == OPC_OPIMM);
                if (arith_ill) begin
                    illegal_o = 1'b1;
                end else begin
                    ctrl_sig_o = arith_ctrl;
                    wr_en_o    = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3_i == 3'b000 || funct3_i == 3'b001) begin
                    ctrl_sig_o  = ALU_CMP;
                    is_branch_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decode, operand forwarding, op2 select, load-use stall.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [4:0]       rs1Addr,
    input  logic [4:0]       rs2Addr,
    input  logic [4:0]       rdAddr,
    input  logic [Width-1:0] rs1Data,
    input  logic [Width-1:0] rs2Data,
    input  logic [Width-1:0] imm,
    input  logic             exWrEn,
    input  logic             exIsLoad,
    input  logic [4:0]       exRd,
    input  logic [Width-1:0] exResult,
    input  logic             memWrEn,
    input  logic [4:0]       memRd,
    input  logic [Width-1:0] memResult,
    output logic             outValid,
    input  logic             outReady,
    output logic [3:0]       ctrlSig,
    output logic [Width-1:0] op1,
    output logic [Width-1:0] op2,
    output logic [4:0]       rdOut,
    output logic             wrEnOut,
    output logic             isBranch,
    output logic             illegal
);

    logic [3:0]       dec_ctrl;
    logic             dec_use_imm;
    logic             dec_branch;
    logic             dec_wr;
    logic             dec_ill;

    logic [Width-1:0] fwd1;
    logic [Width-1:0] fwd2;
    logic             uses_rs2;
    logic             hazard;
    logic             capture;

    logic             valid_q, valid_d;
    logic [3:0]       ctrl_q,  ctrl_d;
    logic [Width-1:0] op1_q,   op1_d;
    logic [Width-1:0] op2_q,   op2_d;
    logic [4:0]       rd_q,    rd_d;
    logic             wr_q,    wr_d;
    logic             br_q,    br_d;
    logic             ill_q,   ill_d;

    alu_ctrl_decode u_dec (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7b5_i  (funct7b5),
        .ctrl_sig_o  (dec_ctrl),
        .use_imm_o   (dec_use_imm),
        .is_branch_o (dec_branch),
        .wr_en_o     (dec_wr),
        .illegal_o   (dec_ill)
    );

    // Source 1 forwarding: EX result wins over MEM, x0 is never forwarded
    always_comb begin
        fwd1 = rs1Data;
        if (exWrEn && exRd == rs1Addr && rs1Addr != 5'd0) begin
            fwd1 = exResult;
        end else if (memWrEn && memRd == rs1Addr && rs1Addr != 5'd0) begin
            fwd1 = memResult;
        end
    end

    // Source 2 forwarding, same priority as source 1
    always_comb begin
        fwd2 = rs2Data;
        if (exWrEn && exRd == rs2Addr && rs2Addr != 5'd0) begin
            fwd2 = exResult;
        end else if (memWrEn && memRd == rs2Addr && rs2Addr != 5'd0) begin
            fwd2 = memResult;
        end
    end

    // Load-use stall: only register-register and branch ops actually read rs2
    always_comb begin
        uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_BRANCH);
        hazard   = inValid && exWrEn && exIsLoad && (exRd != 5'd0) &&
                   ((exRd == rs1Addr) || ((exRd == rs2Addr) && uses_rs2));
        inReady  = !hazard && (!valid_q || outReady);
        capture  = inValid && inReady;
    end

    // Next state of the issue register: capture replaces, consume empties, otherwise hold
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        br_d    = br_q;
        ill_d   = ill_q;
        if (capture) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            op1_d   = fwd1;
            op2_d   = dec_use_imm ? imm : fwd2;
            rd_d    = rdAddr;
            wr_d    = dec_wr && (rdAddr != 5'd0);
            br_d    = dec_branch;
            ill_d   = dec_ill;
        end else if (valid_q && outReady) begin
            valid_d = 1'b0;
        end
    end

    // Issue register, cleared asynchronously
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= 1'b0;
            ctrl_q  <= ALU_NOT;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= 5'd0;
            wr_q    <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign outValid = valid_q;
    assign ctrlSig  = ctrl_q;
    assign op1      = op1_q;
    assign op2      = op2_q;
    assign rdOut    = rd_q;
    assign wrEnOut  = wr_q;
    assign isBranch = br_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expected values.
module tb_alu_issue_stage;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LD  = 7'b0000011;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid, inReady;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic [31:0] rs1Data, rs2Data, imm;
    logic        exWrEn, exIsLoad;
    logic [4:0]  exRd;
    logic [31:0] exResult;
    logic        memWrEn;
    logic [4:0]  memRd;
    logic [31:0] memResult;
    logic        outValid, outReady;
    logic [3:0]  ctrlSig;
    logic [31:0] op1, op2;
    logic [4:0]  rdOut;
    logic        wrEnOut, isBranch, illegal;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.Width(32)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .inValid   (inValid),
        .inReady   (inReady),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .rs1Addr   (rs1Addr),
        .rs2Addr   (rs2Addr),
        .rdAddr    (rdAddr),
        .rs1Data   (rs1Data),
        .rs2Data   (rs2Data),
        .imm       (imm),
        .exWrEn    (exWrEn),
        .exIsLoad  (exIsLoad),
        .exRd      (exRd),
        .exResult  (exResult),
        .memWrEn   (memWrEn),
        .memRd     (memRd),
        .memResult (memResult),
        .outValid  (outValid),
        .outReady  (outReady),
        .ctrlSig   (ctrlSig),
        .op1       (op1),
        .op2       (op2),
        .rdOut     (rdOut),
        .wrEnOut   (wrEnOut),
        .isBranch  (isBranch),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        opcode = opc; funct3 = f3; funct7b5 = b5;
        rs1Addr = r1; rs2Addr = r2; rdAddr = rd;
        rs1Data = d1; rs2Data = d2; imm = im;
    endtask

    task automatic clr_fwd();
        exWrEn = 1'b0; exIsLoad = 1'b0; exRd = 5'd0; exResult = '0;
        memWrEn = 1'b0; memRd = 5'd0; memResult = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
        drive_op(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        clr_fwd();
        repeat (2) step();

        // reset state
        chk("rst_valid", {31'd0, outValid}, 32'd0);
        chk("rst_ctrl",  {28'd0, ctrlSig}, 32'd0);
        chk("rst_op1",   op1, 32'd0);
        chk("rst_op2",   op2, 32'd0);
        chk("rst_flags", {27'd0, rdOut, wrEnOut, isBranch, illegal}, 32'd0);
        @(negedge clk); rstN = 1'b1;

        // SUB x3,x1,x2
        drive_op(OP, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 32'd0);
        inValid = 1'b1;
        step();
        chk("sub_valid", {31'd0, outValid}, 32'd1);
        chk("sub_ctrl",  {28'd0, ctrlSig}, 32'h5);
        chk("sub_op1",   op1, 32'd7);
        chk("sub_op2",   op2, 32'd5);
        chk("sub_rd_wr", {26'd0, rdOut, wrEnOut}, {26'd0, 5'd3, 1'b1});

        // hold, then asynchronous reset mid-cycle
        inValid = 1'b0; outReady = 1'b0;
        step();
        chk("hold_valid", {31'd0, outValid}, 32'd1);
        chk("hold_op1",   op1, 32'd7);
        #2 rstN = 1'b0;
        #1;
        chk("arst_valid", {31'd0, outValid}, 32'd0);
        chk("arst_ctrl",  {28'd0, ctrlSig}, 32'd0);
        chk("arst_ops",   op1 | op2, 32'd0);
        chk("arst_flags", {27'd0, rdOut, wrEnOut, isBranch, illegal}, 32'd0);
        @(negedge clk); rstN = 1'b1;
        drive_op(OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd3, 32'd4, 32'd0);
        inValid = 1'b1; outReady = 1'b1;
        step();
        chk("post_rst_valid", {31'd0, outValid}, 32'd1);
        chk("post_rst_ctrl",  {28'd0, ctrlSig}, 32'h4);
        chk("post_rst_ops",   {op1[15:0], op2[15:0]}, {16'd3, 16'd4});

        // addi x3,x1,4 with EX and MEM both targeting x1
        drive_op(OPI, 3'b000, 1'b0, 5'd1, 5'd4, 5'd3, 32'h99, 32'h0, 32'd4);
        exWrEn = 1'b1; exRd = 5'd1; exResult = 32'hA;
        memWrEn = 1'b1; memRd = 5'd1; memResult = 32'hB;
        step();
        chk("fwd_ex_op1", op1, 32'hA);
        chk("fwd_imm_op2", op2, 32'd4);
        exWrEn = 1'b0;
        step();
        chk("fwd_mem_op1", op1, 32'hB);

        // rs2 forwarded from MEM on AND
        clr_fwd();
        drive_op(OP, 3'b111, 1'b0, 5'd6, 5'd5, 5'd7, 32'h1, 32'h11, 32'd0);
        memWrEn = 1'b1; memRd = 5'd5; memResult = 32'h55;
        step();
        chk("fwd_rs2_op2",  op2, 32'h55);
        chk("fwd_rs2_ctrl", {28'd0, ctrlSig}, 32'h1);

        // x0 is never forwarded
        clr_fwd();
        drive_op(OP, 3'b110, 1'b0, 5'd0, 5'd9, 5'd7, 32'h0, 32'h2, 32'd0);
        exWrEn = 1'b1; exRd = 5'd0; exResult = 32'hDEAD;
        step();
        chk("x0_no_fwd", op1, 32'h0);
        chk("or_ctrl",   {28'd0, ctrlSig}, 32'h2);

        // load-use on x2
        clr_fwd();
        exWrEn = 1'b1; exIsLoad = 1'b1; exRd = 5'd2; exResult = 32'hBAD;
        drive_op(OPI, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8, 32'h10, 32'h0, 32'd1);
        #1;
        chk("opimm_rs2_nostall", {31'd0, inReady}, 32'd1);
        drive_op(OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8, 32'h10, 32'h33, 32'd0);
        #1;
        chk("lu_ready0", {31'd0, inReady}, 32'd0);
        step();
        chk("lu_drained", {31'd0, outValid}, 32'd0);
        chk("lu_ready1", {31'd0, inReady}, 32'd0);
        step();
        chk("lu_ready2", {31'd0, inReady}, 32'd0);
        chk("lu_still_empty", {31'd0, outValid}, 32'd0);
        exIsLoad = 1'b0; exResult = 32'h77;
        #1;
        chk("lu_release", {31'd0, inReady}, 32'd1);
        step();
        chk("lu_issue_valid", {31'd0, outValid}, 32'd1);
        chk("lu_issue_op2",   op2, 32'h77);
        chk("lu_issue_op1",   op1, 32'h10);

        // downstream stall for 3 cycles with a new op waiting
        clr_fwd();
        drive_op(OP, 3'b100, 1'b0, 5'd6, 5'd7, 5'd9, 32'hF0, 32'h0F, 32'd0);
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'd0, inReady}, 32'd0);
            step();
            chk("bp_valid", {31'd0, outValid}, 32'd1);
            chk("bp_hold",  {ctrlSig, op1[11:0], op2[15:0]}, {4'h4, 12'h010, 16'h0077});
        end
        outReady = 1'b1;
        #1;
        chk("bp_release", {31'd0, inReady}, 32'd1);
        step();
        chk("swap_valid", {31'd0, outValid}, 32'd1);
        chk("swap_xor",   {ctrlSig, op1[11:0], op2[15:0]}, {4'h3, 12'h0F0, 16'h000F});

        // decode cases: BEQ, SRA, add to x0, SRLI, SLL, SLT, BLT, load opcode
        drive_op(BR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd1, 32'd0);
        step();
        chk("beq", {24'd0, ctrlSig, wrEnOut, isBranch, illegal, 1'b0}, {24'd0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0});
        drive_op(OP, 3'b101, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0);
        step();
        chk("sra_illegal", {24'd0, ctrlSig, wrEnOut, isBranch, illegal, 1'b0}, {24'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        drive_op(OP, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd1, 32'd0);
        step();
        chk("add_x0", {24'd0, ctrlSig, wrEnOut, isBranch, illegal, 1'b0}, {24'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_op(OPI, 3'b101, 1'b0, 5'd1, 5'd3, 5'd3, 32'd1, 32'd9, 32'd3);
        step();
        chk("srli", {ctrlSig, wrEnOut, illegal, op2[25:0]}, {4'h6, 1'b1, 1'b0, 26'd3});
        drive_op(OP, 3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0);
        step();
        chk("sll", {28'd0, ctrlSig}, 32'h7);
        drive_op(OP, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0);
        step();
        chk("slt", {28'd0, ctrlSig}, 32'h8);
        drive_op(BR, 3'b100, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0);
        step();
        chk("blt_illegal", {24'd0, ctrlSig, wrEnOut, isBranch, illegal, 1'b0}, {24'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        drive_op(LD, 3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0);
        step();
        chk("load_illegal", {30'd0, wrEnOut, illegal}, {30'd0, 1'b0, 1'b1});

        // drain
        inValid = 1'b0;
        step();
        chk("drain_valid", {31'd0, outValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
